// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: CSR register offsets,
// CTRL bit positions, bus widths and the output sequencer state encoding.
package irq_ctrl_pkg;

    localparam int CSR_AW = 5;
    localparam int CSR_DW = 8;

    // Register offsets relative to BASE_ADDR
    localparam logic [1:0] REG_IE   = 2'd0;
    localparam logic [1:0] REG_IP   = 2'd1;
    localparam logic [1:0] REG_EDGE = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    // CTRL register bit positions
    localparam int CTRL_GIE    = 0;
    localparam int CTRL_RETRIG = 1;

    // Output sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// CSR bus bundle shared by the peripherals behind the I2C slave.
// The master drives address/data/strobe; each slave returns read data
// that is zero outside its own window so slaves can be OR-combined.
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic [CSR_AW-1:0] csr_a;
    logic [CSR_DW-1:0] csr_di;
    logic              csr_we;
    logic [CSR_DW-1:0] csr_do;

    modport master (
        output csr_a,
        output csr_di,
        output csr_we,
        input  csr_do
    );

    modport slave (
        input  csr_a,
        input  csr_di,
        input  csr_we,
        output csr_do
    );
endinterface

// File: rtl/irq_ctrl_src.sv
// One interrupt source: input history register for edge detection and the
// pending bit. A set condition beats a simultaneous write-1-to-clear, so a
// level source stays pending for as long as its input is high.
module irq_ctrl_src (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    input  logic edge_sel,
    input  logic w1c,
    output logic pend,
    output logic pend_next
);

    logic irq_q;
    logic set_cond;

    // Input history loads even during reset so leaving reset with the
    // input already high is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        irq_q <= irq_in;
    end

    assign set_cond  = edge_sel ? (irq_in & ~irq_q) : irq_in;
    assign pend_next = set_cond | (pend & ~w1c);

    // Pending bit register
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
        end else begin
            pend <= pend_next;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source pending bits with enable and edge/level
// selection, CSR decode on the shared 5-bit bus, and a sequencer that drives
// a single registered interrupt line with a guaranteed minimum low time
// between assertions.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter logic [CSR_AW-1:0] BASE_ADDR  = 5'h1c,
    parameter int                NUM_IRQS   = 8,
    parameter int                GAP_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    irq_ctrl_if.slave           csr,
    input  logic [NUM_IRQS-1:0] irq_in,
    output logic                irq_out
);

    localparam int CW = $clog2(GAP_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LOAD = CW'(GAP_CYCLES - 1);

    logic [NUM_IRQS-1:0] ie_reg;
    logic [NUM_IRQS-1:0] edge_reg;
    logic                gie_reg;
    logic                retrig_reg;
    logic [NUM_IRQS-1:0] ip_reg;
    logic [NUM_IRQS-1:0] ip_next;
    logic [NUM_IRQS-1:0] w1c;

    state_t              state_reg;
    state_t              state_next;
    logic [CW-1:0]       cnt_reg;
    logic [CW-1:0]       cnt_next;
    logic                irq_out_reg;

    logic [CSR_AW-1:0]   off;
    logic                hit;
    logic [1:0]          sel;
    logic                active;
    logic                newp;

    // Address window: subtracting the base lets one compare cover the
    // four-register block without worrying about where BASE_ADDR sits.
    assign off = csr.csr_a - BASE_ADDR;
    assign hit = (off[CSR_AW-1:2] == '0);
    assign sel = off[1:0];

    assign w1c = (csr.csr_we && hit && (sel == REG_IP)) ?
                 csr.csr_di[NUM_IRQS-1:0] : '0;

    // Control/enable registers written from the CSR bus
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_reg     <= '0;
            edge_reg   <= '0;
            gie_reg    <= 1'b0;
            retrig_reg <= 1'b0;
        end else if (csr.csr_we && hit) begin
            case (sel)
                REG_IE:   ie_reg   <= csr.csr_di[NUM_IRQS-1:0];
                REG_EDGE: edge_reg <= csr.csr_di[NUM_IRQS-1:0];
                REG_CTRL: begin
                    gie_reg    <= csr.csr_di[CTRL_GIE];
                    retrig_reg <= csr.csr_di[CTRL_RETRIG];
                end
                default: ;
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_IRQS; gi++) begin : g_src
            irq_ctrl_src u_src (
                .clk       (clk),
                .rst       (rst),
                .irq_in    (irq_in[gi]),
                .edge_sel  (edge_reg[gi]),
                .w1c       (w1c[gi]),
                .pend      (ip_reg[gi]),
                .pend_next (ip_next[gi])
            );
        end
    endgenerate

    assign active = gie_reg & (|(ip_reg & ie_reg));
    // An enabled bit going 0->1 this cycle; used to force a fresh edge
    // on the SoC side when RETRIG is set.
    assign newp   = |(ip_next & ~ip_reg & ie_reg);

    // Combinational read mux; unused upper bits and out-of-window reads are 0
    always_comb begin
        csr.csr_do = '0;
        if (hit) begin
            case (sel)
                REG_IE:   csr.csr_do[NUM_IRQS-1:0] = ie_reg;
                REG_IP:   csr.csr_do[NUM_IRQS-1:0] = ip_reg;
                REG_EDGE: csr.csr_do[NUM_IRQS-1:0] = edge_reg;
                REG_CTRL: begin
                    csr.csr_do[CTRL_GIE]    = gie_reg;
                    csr.csr_do[CTRL_RETRIG] = retrig_reg;
                end
                default: ;
            endcase
        end
    end

    // Sequencer state, gap counter and output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            irq_out_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            irq_out_reg <= (state_next == ASSERT);
        end
    end

    // Next-state logic: the counter is loaded on entry to GAP so the line
    // stays low for exactly GAP_CYCLES cycles before it may reassert.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                if (active) begin
                    state_next = ASSERT;
                end
            end
            ASSERT: begin
                if (!active || (retrig_reg && newp)) begin
                    state_next = GAP;
                    cnt_next   = GAP_LOAD;
                end
            end
            GAP: begin
                if (cnt_reg == '0) begin
                    state_next = active ? ASSERT : IDLE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign irq_out = irq_out_reg;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: expected values are queued as each step is
// driven and popped when the corresponding DUT output is sampled.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam logic [4:0] BASE = 5'h1c;
    localparam int         GAP_C = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] irq_in = 8'h00;
    logic       irq_out;

    irq_ctrl_if csr ();

    irq_ctrl #(
        .BASE_ADDR  (BASE),
        .NUM_IRQS   (8),
        .GAP_CYCLES (GAP_C)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .csr     (csr),
        .irq_in  (irq_in),
        .irq_out (irq_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic check(input logic [7:0] obs);
        exp_t e;
        n_cmp++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            $display("chk %-16s observed=%h expected=%h", e.tag, obs, e.val);
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wr(input logic [1:0] offs, input logic [7:0] d);
        csr.csr_a  = BASE + {3'b000, offs};
        csr.csr_di = d;
        csr.csr_we = 1'b1;
        tick();
        csr.csr_we = 1'b0;
        csr.csr_a  = 5'h00;
        csr.csr_di = 8'h00;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [7:0] exp_v);
        push(tag, exp_v);
        csr.csr_a = addr;
        #1;
        check(csr.csr_do);
        csr.csr_a = 5'h00;
    endtask

    task automatic out_chk(input string tag, input logic exp_v);
        push(tag, {7'b0, exp_v});
        check({7'b0, irq_out});
    endtask

    task automatic count_low(output int low);
        low = 0;
        while (irq_out == 1'b0 && low < 50) begin
            low++;
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        int low;
        int highs;

        csr.csr_a  = 5'h00;
        csr.csr_di = 8'h00;
        csr.csr_we = 1'b0;

        // Reset defaults
        do_reset();
        rd_chk("rst_ie",   BASE + 5'd0, 8'h00);
        rd_chk("rst_ip",   BASE + 5'd1, 8'h00);
        rd_chk("rst_edge", BASE + 5'd2, 8'h00);
        rd_chk("rst_ctrl", BASE + 5'd3, 8'h00);
        rd_chk("rst_addr0", 5'h00, 8'h00);
        irq_in = 8'hff;
        tick(); tick(); tick();
        out_chk("rst_out_masked", 1'b0);
        rd_chk("ip_unmasked", BASE + 5'd1, 8'hff);
        rd_chk("oor_addr0", 5'h00, 8'h00);
        rd_chk("oor_addr1b", 5'h1b, 8'h00);
        irq_in = 8'h00;

        // Level source
        do_reset();
        wr(REG_IE, 8'h01);
        wr(REG_CTRL, 8'h01);
        irq_in = 8'h01;
        tick();
        out_chk("lvl_lat1", 1'b0);
        tick();
        out_chk("lvl_lat2", 1'b1);
        rd_chk("lvl_ip", BASE + 5'd1, 8'h01);
        wr(REG_IP, 8'h01);
        rd_chk("lvl_w1c_held", BASE + 5'd1, 8'h01);
        out_chk("lvl_out_held", 1'b1);
        irq_in = 8'h00;
        wr(REG_IP, 8'h01);
        rd_chk("lvl_w1c_clr", BASE + 5'd1, 8'h00);
        out_chk("lvl_out_k", 1'b1);
        tick();
        out_chk("lvl_out_k1", 1'b0);

        // Edge source
        do_reset();
        wr(REG_EDGE, 8'h02);
        wr(REG_IE, 8'h02);
        wr(REG_CTRL, 8'h01);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        rd_chk("edge_ip", BASE + 5'd1, 8'h02);
        out_chk("edge_lat1", 1'b0);
        tick();
        out_chk("edge_lat2", 1'b1);
        wr(REG_IP, 8'h02);
        rd_chk("edge_w1c", BASE + 5'd1, 8'h00);
        tick();
        out_chk("edge_fall", 1'b0);
        irq_in = 8'h02;
        tick(); tick();
        rd_chk("edge_hold_set", BASE + 5'd1, 8'h02);
        wr(REG_IP, 8'h02);
        rd_chk("edge_hold_once", BASE + 5'd1, 8'h00);
        tick();
        rd_chk("edge_hold_once2", BASE + 5'd1, 8'h00);
        irq_in = 8'h00;

        // Gap enforcement
        do_reset();
        wr(REG_EDGE, 8'hff);
        wr(REG_IE, 8'hff);
        wr(REG_CTRL, 8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        out_chk("gap_pre", 1'b1);
        wr(REG_IP, 8'h01);
        out_chk("gap_k", 1'b1);
        irq_in = 8'h02;
        tick();
        irq_in = 8'h00;
        count_low(low);
        push("gap_low_cycles", 8'(GAP_C));
        check(8'(low));
        out_chk("gap_reassert", 1'b1);

        // RETRIG enabled
        do_reset();
        wr(REG_EDGE, 8'hff);
        wr(REG_IE, 8'hff);
        wr(REG_CTRL, 8'h03);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        out_chk("rt_pre", 1'b1);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        out_chk("rt_drop", 1'b0);
        count_low(low);
        push("rt_low_cycles", 8'(GAP_C));
        check(8'(low));
        out_chk("rt_rise", 1'b1);

        // RETRIG disabled: same stimulus, no gap
        do_reset();
        wr(REG_EDGE, 8'hff);
        wr(REG_IE, 8'hff);
        wr(REG_CTRL, 8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        tick();
        out_chk("nrt_pre", 1'b1);
        irq_in = 8'h04;
        tick();
        irq_in = 8'h00;
        highs = 0;
        for (int i = 0; i < 6; i++) begin
            if (irq_out) highs++;
            tick();
        end
        push("nrt_high_cycles", 8'd6);
        check(8'(highs));
        rd_chk("nrt_ip", BASE + 5'd1, 8'h05);

        // Masking, then reset in the middle of GAP
        do_reset();
        wr(REG_EDGE, 8'h01);
        wr(REG_IE, 8'h00);
        wr(REG_CTRL, 8'h01);
        irq_in = 8'h01;
        tick();
        irq_in = 8'h00;
        rd_chk("mask_ip", BASE + 5'd1, 8'h01);
        tick(); tick();
        out_chk("mask_out", 1'b0);
        wr(REG_IE, 8'h01);
        out_chk("unmask_k", 1'b0);
        tick();
        out_chk("unmask_k1", 1'b1);
        wr(REG_IE, 8'h03);
        wr(REG_IP, 8'h01);
        tick();
        out_chk("mrst_in_gap", 1'b0);
        irq_in = 8'h02;
        tick();
        rst = 1'b1;
        irq_in = 8'h00;
        tick();
        out_chk("mrst_out", 1'b0);
        rd_chk("mrst_ip", BASE + 5'd1, 8'h00);
        rd_chk("mrst_ie", BASE + 5'd0, 8'h00);
        rst = 1'b0;
        repeat (6) tick();
        out_chk("mrst_stays_idle", 1'b0);

        if (sb.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
